// File: rtl/cdb_arbiter.sv
// Purpose: buffers one result per producer (ADD1-3, MULT1-2, LS) and broadcasts one (tag, value) per cycle on the CDB, round-robin.
// Latency: offer accepted at cycle N, slot full at N+1, earliest CDB_valid at N+2.
// Backpressure: X_ready = ~full[X]; a producer holds its offer until its slot drains, and flush discards everything including same-cycle offers.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ADD1_valid,
    input  logic              ADD2_valid,
    input  logic              ADD3_valid,
    input  logic              MULT1_valid,
    input  logic              MULT2_valid,
    input  logic [DATA_W-1:0] ADD1_result,
    input  logic [DATA_W-1:0] ADD2_result,
    input  logic [DATA_W-1:0] ADD3_result,
    input  logic [DATA_W-1:0] MULT1_result,
    input  logic [DATA_W-1:0] MULT2_result,
    output logic              ADD1_ready,
    output logic              ADD2_ready,
    output logic              ADD3_ready,
    output logic              MULT1_ready,
    output logic              MULT2_ready,
    input  logic              LS_valid,
    input  logic [DATA_W-1:0] LS_value,
    input  logic [2:0]        LS_idx,
    output logic              LS_ready,
    output logic              CDB_valid,
    output logic [TAG_W-1:0]  CDB_tag,
    output logic [DATA_W-1:0] CDB_value,
    output logic              LS_idx_err
);

    // Slot order 0..5 = ADD1, ADD2, ADD3, MULT1, MULT2, LS.
    localparam int          N_SLOT  = 6;
    localparam logic [2:0]  LS_SLOT = 3'd5;

    logic [N_SLOT-1:0] r_full;
    logic [DATA_W-1:0] r_val [N_SLOT];
    logic [TAG_W-1:0]  r_tag [N_SLOT];
    logic [2:0]        r_last;
    logic              r_cdb_vld;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_dat;
    logic              r_idx_err;

    logic [N_SLOT-1:0] w_in_vld;
    logic [DATA_W-1:0] w_in_dat [N_SLOT];
    logic [TAG_W-1:0]  w_in_tag [N_SLOT];
    logic [N_SLOT-1:0] w_cap;
    logic              w_ls_bad;
    logic              w_gnt_vld;
    logic [2:0]        w_gnt_idx;
    logic [3:0]        w_sum;

    assign w_in_vld = {LS_valid, MULT2_valid, MULT1_valid, ADD3_valid, ADD2_valid, ADD1_valid};

    assign w_in_dat[0] = ADD1_result;
    assign w_in_dat[1] = ADD2_result;
    assign w_in_dat[2] = ADD3_result;
    assign w_in_dat[3] = MULT1_result;
    assign w_in_dat[4] = MULT2_result;
    assign w_in_dat[5] = LS_value;

    assign w_in_tag[0] = TAG_W'(7);
    assign w_in_tag[1] = TAG_W'(8);
    assign w_in_tag[2] = TAG_W'(9);
    assign w_in_tag[3] = TAG_W'(10);
    assign w_in_tag[4] = TAG_W'(11);
    assign w_in_tag[5] = TAG_W'(LS_idx);

    // LS tags 0 and 7 are not real producers; such offers are swallowed.
    assign w_ls_bad = (LS_idx == 3'd0) || (LS_idx == 3'd7);

    // Ready depends only on slot state, never on this cycle's arbitration.
    assign ADD1_ready  = ~r_full[0];
    assign ADD2_ready  = ~r_full[1];
    assign ADD3_ready  = ~r_full[2];
    assign MULT1_ready = ~r_full[3];
    assign MULT2_ready = ~r_full[4];
    assign LS_ready    = ~r_full[5];

    // Capture qualification: handshake, no flush, and a legal LS tag for the LS slot.
    always_comb begin
        w_cap = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            w_cap[i] = w_in_vld[i] & ~r_full[i] & ~flush;
        end
        w_cap[LS_SLOT] = w_cap[LS_SLOT] & ~w_ls_bad;
    end

    // Round-robin search starting one past the last granted slot, wrapping mod 6.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_last;
        w_sum     = '0;
        for (int off = 1; off <= N_SLOT; off++) begin
            w_sum = {1'b0, r_last} + 4'(off);
            if (w_sum >= 4'(N_SLOT)) begin
                w_sum = w_sum - 4'(N_SLOT);
            end
            if (!w_gnt_vld && r_full[w_sum[2:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_sum[2:0];
            end
        end
    end

    // Slot storage: fill on capture, drain on grant, clear everything on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
            for (int i = 0; i < N_SLOT; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (flush) begin
            r_full <= '0;
        end else begin
            for (int i = 0; i < N_SLOT; i++) begin
                if (w_cap[i]) begin
                    r_full[i] <= 1'b1;
                    r_val[i]  <= w_in_dat[i];
                    r_tag[i]  <= w_in_tag[i];
                end else if (w_gnt_vld && (w_gnt_idx == 3'(i))) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // CDB output register and round-robin pointer; value holds when idle or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_vld <= 1'b0;
            r_cdb_tag <= '0;
            r_cdb_dat <= '0;
            r_last    <= LS_SLOT;
        end else if (flush || !w_gnt_vld) begin
            r_cdb_vld <= 1'b0;
            r_cdb_tag <= '0;
        end else begin
            r_cdb_vld <= 1'b1;
            r_cdb_tag <= r_tag[w_gnt_idx];
            r_cdb_dat <= r_val[w_gnt_idx];
            r_last    <= w_gnt_idx;
        end
    end

    // One-cycle pulse when an illegal LS tag is accepted and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_err <= 1'b0;
        end else begin
            r_idx_err <= LS_valid & ~r_full[LS_SLOT] & w_ls_bad & ~flush;
        end
    end

    assign CDB_valid  = r_cdb_vld;
    assign CDB_tag    = r_cdb_tag;
    assign CDB_value  = r_cdb_dat;
    assign LS_idx_err = r_idx_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose: directed stimulus for cdb_arbiter with a broadcast scoreboard and per-cycle handshake checks.
// Latency: expected broadcasts are queued at offer time and popped by the monitor on each CDB_valid.
// Backpressure: offers are scheduled from hand-traced slot occupancy, not from sampled ready.
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              ADD1_valid, ADD2_valid, ADD3_valid, MULT1_valid, MULT2_valid, LS_valid;
    logic [DATA_W-1:0] ADD1_result, ADD2_result, ADD3_result, MULT1_result, MULT2_result, LS_value;
    logic [2:0]        LS_idx;
    logic              ADD1_ready, ADD2_ready, ADD3_ready, MULT1_ready, MULT2_ready, LS_ready;
    logic              CDB_valid;
    logic [TAG_W-1:0]  CDB_tag;
    logic [DATA_W-1:0] CDB_value;
    logic              LS_idx_err;
    logic [5:0]        rdy;

    int n_vec = 0;
    int n_err = 0;
    logic [TAG_W+DATA_W-1:0] exp_q [$];
    logic [TAG_W+DATA_W-1:0] mon_exp;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ADD1_valid(ADD1_valid), .ADD2_valid(ADD2_valid), .ADD3_valid(ADD3_valid),
        .MULT1_valid(MULT1_valid), .MULT2_valid(MULT2_valid),
        .ADD1_result(ADD1_result), .ADD2_result(ADD2_result), .ADD3_result(ADD3_result),
        .MULT1_result(MULT1_result), .MULT2_result(MULT2_result),
        .ADD1_ready(ADD1_ready), .ADD2_ready(ADD2_ready), .ADD3_ready(ADD3_ready),
        .MULT1_ready(MULT1_ready), .MULT2_ready(MULT2_ready),
        .LS_valid(LS_valid), .LS_value(LS_value), .LS_idx(LS_idx), .LS_ready(LS_ready),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_value(CDB_value), .LS_idx_err(LS_idx_err)
    );

    always #5 clk = ~clk;

    assign rdy = {LS_ready, MULT2_ready, MULT1_ready, ADD3_ready, ADD2_ready, ADD1_ready};

    // Monitor: every broadcast must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && CDB_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cdb_unexpected: got tag %0d value %0h, expected no broadcast", CDB_tag, CDB_value);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({CDB_tag, CDB_value} !== mon_exp) begin
                    n_err++;
                    $display("FAIL cdb_bcast: got tag %0d value %0h, expected tag %0d value %0h",
                             CDB_tag, CDB_value, mon_exp[TAG_W+DATA_W-1:DATA_W], mon_exp[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bcast(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val);
        exp_q.push_back({tag, val});
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        ADD1_valid  = 1'b0; ADD2_valid = 1'b0; ADD3_valid = 1'b0;
        MULT1_valid = 1'b0; MULT2_valid = 1'b0; LS_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        ADD1_result = '0; ADD2_result = '0; ADD3_result = '0;
        MULT1_result = '0; MULT2_result = '0; LS_value = '0; LS_idx = 3'd1;

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_cdb_valid", 64'(CDB_valid), 64'd0);
        check("rst_cdb_tag",   64'(CDB_tag),   64'd0);
        check("rst_cdb_value", 64'(CDB_value), 64'd0);
        check("rst_idx_err",   64'(LS_idx_err), 64'd0);
        check("rst_ready",     64'(rdy),       64'h3F);
        do_reset();

        // Single ADD2 offer.
        ADD2_valid = 1'b1; ADD2_result = 32'h0000_00AA;
        expect_bcast(4'd8, 32'h0000_00AA);
        step();
        ADD2_valid = 1'b0;
        @(negedge clk);
        check("single_ready_low", 64'(ADD2_ready), 64'd0);
        check("single_no_cdb_yet", 64'(CDB_valid), 64'd0);
        step();
        @(negedge clk);
        check("single_cdb_valid", 64'(CDB_valid), 64'd1);
        check("single_ready_high", 64'(ADD2_ready), 64'd1);
        step();
        @(negedge clk);
        check("single_idle_valid", 64'(CDB_valid), 64'd0);
        check("single_idle_tag",   64'(CDB_tag),   64'd0);
        check("single_value_hold", 64'(CDB_value), 64'hAA);

        // All six sources offer together right after reset.
        do_reset();
        ADD1_valid = 1'b1;  ADD1_result  = 32'h1111_0001;
        ADD2_valid = 1'b1;  ADD2_result  = 32'h2222_0002;
        ADD3_valid = 1'b1;  ADD3_result  = 32'h3333_0003;
        MULT1_valid = 1'b1; MULT1_result = 32'h4444_0004;
        MULT2_valid = 1'b1; MULT2_result = 32'h5555_0005;
        LS_valid = 1'b1;    LS_value     = 32'h6666_0006; LS_idx = 3'd4;
        expect_bcast(4'd7,  32'h1111_0001);
        expect_bcast(4'd8,  32'h2222_0002);
        expect_bcast(4'd9,  32'h3333_0003);
        expect_bcast(4'd10, 32'h4444_0004);
        expect_bcast(4'd11, 32'h5555_0005);
        expect_bcast(4'd4,  32'h6666_0006);
        step();
        idle_inputs();
        @(negedge clk);
        check("all6_ready_low", 64'(rdy), 64'h00);
        check("all6_no_err", 64'(LS_idx_err), 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check("all6_cdb_continuous", 64'(CDB_valid), 64'd1);
        end
        step();
        @(negedge clk);
        check("all6_cdb_done", 64'(CDB_valid), 64'd0);

        // Fairness: ADD1 and MULT2 offering every cycle; accepts traced by hand.
        // ADD1 accepted in cycles 1,3,5,7; MULT2 in cycles 1,4,6,8.
        step();
        expect_bcast(4'd7,  32'h101);
        expect_bcast(4'd11, 32'h201);
        expect_bcast(4'd7,  32'h103);
        expect_bcast(4'd11, 32'h204);
        expect_bcast(4'd7,  32'h105);
        expect_bcast(4'd11, 32'h206);
        expect_bcast(4'd7,  32'h107);
        expect_bcast(4'd11, 32'h208);
        for (int k = 1; k <= 8; k++) begin
            ADD1_valid = 1'b1;  ADD1_result  = 32'h100 + 32'(k);
            MULT2_valid = 1'b1; MULT2_result = 32'h200 + 32'(k);
            if (k >= 3) begin
                @(negedge clk);
                check("fair_cdb_continuous", 64'(CDB_valid), 64'd1);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("fair_cdb_c9", 64'(CDB_valid), 64'd1);
        step();
        @(negedge clk);
        check("fair_cdb_c10", 64'(CDB_valid), 64'd1);
        step();
        @(negedge clk);
        check("fair_cdb_drained", 64'(CDB_valid), 64'd0);

        // Illegal LS tags 0 and 7.
        for (int t = 0; t < 2; t++) begin
            step();
            LS_valid = 1'b1; LS_value = 32'hDEAD_0000 + 32'(t);
            LS_idx = (t == 0) ? 3'd0 : 3'd7;
            step();
            LS_valid = 1'b0;
            @(negedge clk);
            check("bad_idx_err_pulse", 64'(LS_idx_err), 64'd1);
            check("bad_idx_ls_ready",  64'(LS_ready),   64'd1);
            check("bad_idx_no_cdb",    64'(CDB_valid),  64'd0);
            step();
            @(negedge clk);
            check("bad_idx_err_clear", 64'(LS_idx_err), 64'd0);
            check("bad_idx_no_cdb2",   64'(CDB_valid),  64'd0);
        end

        // Flush with ADD1, MULT1, LS full and an ADD3 offer in the flush cycle.
        step();
        ADD1_valid = 1'b1;  ADD1_result  = 32'hF100_0001;
        MULT1_valid = 1'b1; MULT1_result = 32'hF400_0004;
        LS_valid = 1'b1;    LS_value     = 32'hF600_0006; LS_idx = 3'd2;
        step();
        idle_inputs();
        flush = 1'b1;
        ADD3_valid = 1'b1; ADD3_result = 32'hF300_0003;
        step();
        idle_inputs();
        @(negedge clk);
        check("flush_cdb_valid", 64'(CDB_valid), 64'd0);
        check("flush_cdb_tag",   64'(CDB_tag),   64'd0);
        check("flush_ready",     64'(rdy),       64'h3F);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            check("flush_no_bcast", 64'(CDB_valid), 64'd0);
        end

        // Reset mid-operation with three full slots; last grant was MULT2 so ADD1 goes first.
        step();
        ADD1_valid = 1'b1;  ADD1_result  = 32'hA100_0001;
        ADD2_valid = 1'b1;  ADD2_result  = 32'hA200_0002;
        MULT2_valid = 1'b1; MULT2_result = 32'hA500_0005;
        expect_bcast(4'd7, 32'hA100_0001);
        step();
        idle_inputs();
        step();
        @(negedge clk);
        check("midrst_pre_valid", 64'(CDB_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cdb_valid", 64'(CDB_valid), 64'd0);
        check("midrst_cdb_tag",   64'(CDB_tag),   64'd0);
        check("midrst_ready",     64'(rdy),       64'h3F);
        step();
        rst_n = 1'b1;
        ADD1_valid = 1'b1; ADD1_result = 32'h0000_0055;
        expect_bcast(4'd7, 32'h0000_0055);
        step();
        idle_inputs();
        @(negedge clk);
        check("postrst_no_cdb_yet", 64'(CDB_valid), 64'd0);
        step();
        @(negedge clk);
        check("postrst_cdb_valid", 64'(CDB_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("postrst_no_stale", 64'(CDB_valid), 64'd0);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
